// File: rtl/slink_apb_arb_pkg.sv
// Shared types and constants for the S-Link APB arbiter and its round-robin picker.
package slink_apb_arb_pkg;

    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

    // Index width for a set of n requesters, never narrower than one bit.
    function automatic int ptr_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slink_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_INIT.
module slink_rr_arb
    import slink_apb_arb_pkg::*;
#(
    parameter int NUM_INIT = 2,
    parameter int IDX_W    = ptr_w(NUM_INIT)
) (
    input  logic [NUM_INIT-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                any_req
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = NUM_INIT - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_INIT);
            if (req[cand]) begin
                gnt_idx = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slink_apb_arb.sv
// Round-robin arbiter sharing one APB target between NUM_INIT initiators,
// with a watchdog that error-completes accesses hung on a dead link.
//
//   state  | meaning
//   IDLE   | no access in flight, arbitrating between requesters
//   SETUP  | downstream APB setup phase for the granted initiator
//   ACCESS | downstream access phase, watchdog counting
//   DRAIN  | watchdog already answered; waiting out the late downstream response
module slink_apb_arb
    import slink_apb_arb_pkg::*;
#(
    parameter int NUM_INIT       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       apb_clk,
    input  logic                       apb_reset,
    input  logic [NUM_INIT*APB_DW-1:0] s_paddr,
    input  logic [NUM_INIT-1:0]        s_pwrite,
    input  logic [NUM_INIT-1:0]        s_psel,
    input  logic [NUM_INIT-1:0]        s_penable,
    input  logic [NUM_INIT*APB_DW-1:0] s_pwdata,
    output logic [NUM_INIT*APB_DW-1:0] s_prdata,
    output logic [NUM_INIT-1:0]        s_pready,
    output logic [NUM_INIT-1:0]        s_pslverr,
    output logic [APB_DW-1:0]          m_paddr,
    output logic                       m_pwrite,
    output logic                       m_psel,
    output logic                       m_penable,
    output logic [APB_DW-1:0]          m_pwdata,
    input  logic [APB_DW-1:0]          m_prdata,
    input  logic                       m_pready,
    input  logic                       m_pslverr,
    output logic                       timeout_evt
);

    localparam int IDX_W = ptr_w(NUM_INIT);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, ptr_q, rr_idx;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_any, wd_fire, resp_done;
    logic             penable_unused;

    // Initiator phase is irrelevant here: a raised psel is already a request.
    assign penable_unused = ^s_penable;

    slink_rr_arb #(.NUM_INIT(NUM_INIT), .IDX_W(IDX_W)) u_rr (
        .req     (s_psel),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .any_req (rr_any)
    );

    // cnt_q holds completed ACCESS cycles, so cycle N of ACCESS sees N-1.
    assign wd_fire   = WD_EN && (state_q == ST_ACCESS) && !m_pready && (cnt_q == CNT_LAST);
    assign resp_done = (state_q == ST_ACCESS) && (m_pready || wd_fire);

    always_ff @(posedge apb_clk or posedge apb_reset) begin
        if (apb_reset) begin
            state_q   <= ST_IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_psel    <= (state_d != ST_IDLE);
            m_penable <= (state_d == ST_ACCESS) || (state_d == ST_DRAIN);
            if (state_q == ST_IDLE && rr_any) begin
                gnt_q <= rr_idx;
                for (int i = 0; i < NUM_INIT; i++) begin
                    if (rr_idx == IDX_W'(i)) begin
                        m_paddr  <= s_paddr[APB_DW*i +: APB_DW];
                        m_pwrite <= s_pwrite[i];
                        m_pwdata <= s_pwdata[APB_DW*i +: APB_DW];
                    end
                end
            end
            if (resp_done) begin
                ptr_q <= (gnt_q == IDX_W'(NUM_INIT - 1)) ? '0 : gnt_q + IDX_W'(1);
            end
            if (state_q == ST_ACCESS) begin
                cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rr_any) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (m_pready)     state_d = ST_IDLE;
                else if (wd_fire) state_d = ST_DRAIN;
            end
            ST_DRAIN:  if (m_pready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // An initiator that abandoned its access mid-flight gets no response.
    always_comb begin
        s_pready    = '0;
        s_pslverr   = '0;
        s_prdata    = '0;
        timeout_evt = wd_fire;
        for (int i = 0; i < NUM_INIT; i++) begin
            if (resp_done && gnt_q == IDX_W'(i) && s_psel[i]) begin
                s_pready[i]                  = 1'b1;
                s_pslverr[i]                 = m_pready ? m_pslverr : 1'b1;
                s_prdata[APB_DW*i +: APB_DW] = m_pready ? m_prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_slink_apb_arb.sv
// Scoreboard bench for slink_apb_arb: three initiators, 16-cycle watchdog, random APB traffic.
module tb_slink_apb_arb;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            apb_clk = 1'b0;
    logic            apb_reset;
    logic [N*32-1:0] s_paddr, s_pwdata, s_prdata;
    logic [N-1:0]    s_pwrite, s_psel, s_penable, s_pready, s_pslverr;
    logic [31:0]     m_paddr, m_pwdata, m_prdata;
    logic            m_pwrite, m_psel, m_penable, m_pready, m_pslverr, timeout_evt;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    typedef struct {
        int          dly;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    txn_t        pend_q[N][$];
    txn_t        mq[N][$];
    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          forced_dly[$];
    logic [31:0] forced_data[$];
    int          mptr;
    int          checks   = 0;
    int          failures = 0;

    slink_apb_arb #(.NUM_INIT(N), .TIMEOUT_CYCLES(TO)) dut (
        .apb_clk     (apb_clk),
        .apb_reset   (apb_reset),
        .s_paddr     (s_paddr),
        .s_pwrite    (s_pwrite),
        .s_psel      (s_psel),
        .s_penable   (s_penable),
        .s_pwdata    (s_pwdata),
        .s_prdata    (s_prdata),
        .s_pready    (s_pready),
        .s_pslverr   (s_pslverr),
        .m_paddr     (m_paddr),
        .m_pwrite    (m_pwrite),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwdata    (m_pwdata),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_pslverr   (m_pslverr),
        .timeout_evt (timeout_evt)
    );

    always #5 apb_clk = ~apb_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Initiators: each holds psel with its head transaction until it sees its pready.
    initial begin : driver
        logic [N-1:0] done;
        int           age[N];
        s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0; s_pwdata = '0;
        for (int i = 0; i < N; i++) age[i] = 0;
        forever begin
            @(negedge apb_clk);
            done = s_pready;
            @(posedge apb_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (done[i] && pend_q[i].size() > 0) begin
                    void'(pend_q[i].pop_front());
                    age[i] = 0;
                end else if (pend_q[i].size() > 0) begin
                    age[i]++;
                end else begin
                    age[i] = 0;
                end
                if (pend_q[i].size() > 0) begin
                    s_psel[i]             = 1'b1;
                    s_penable[i]          = (age[i] > 0);
                    s_pwrite[i]           = pend_q[i][0].wr;
                    s_paddr[32*i +: 32]   = pend_q[i][0].addr;
                    s_pwdata[32*i +: 32]  = pend_q[i][0].wdata;
                end else begin
                    s_psel[i]    = 1'b0;
                    s_penable[i] = 1'b0;
                end
            end
        end
    end

    // Downstream target: answers each access after its planned number of ACCESS-phase cycles.
    initial begin : responder
        int   k;
        rsp_t cur;
        k = 0;
        cur.dly = 0; cur.rdata = '0; cur.err = 1'b0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        forever begin
            @(posedge apb_clk);
            #1;
            m_pready  = 1'b0;
            m_prdata  = $urandom;
            m_pslverr = 1'($urandom_range(0, 1));
            if (apb_reset) begin
                k = 0;
            end else if (m_psel && m_penable) begin
                k++;
                if (k == 1) begin
                    if (rsp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unplanned_access: addr %h with no planned response", m_paddr);
                        cur.dly = 1; cur.rdata = '0; cur.err = 1'b0;
                    end else begin
                        cur = rsp_q.pop_front();
                    end
                end
                if (k == cur.dly) begin
                    m_pready  = 1'b1;
                    m_prdata  = cur.rdata;
                    m_pslverr = cur.err;
                end
            end else begin
                if (k > 0) chk("access_len", 128'(k), 128'(cur.dly));
                k = 0;
            end
        end
    end

    initial begin : monitor
        exp_t         e;
        logic [N-1:0] x_rdy, x_err;
        logic [N*32-1:0] x_rd;
        forever begin
            @(negedge apb_clk);
            if (!apb_reset) begin
                if (s_pready != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp: pready %b with nothing outstanding", s_pready);
                    end else begin
                        e = exp_q.pop_front();
                        x_rdy = '0; x_err = '0; x_rd = '0;
                        x_rdy[e.idx]          = 1'b1;
                        x_err[e.idx]          = e.err;
                        x_rd[32*e.idx +: 32]  = e.rdata;
                        chk("s_pready", 128'(s_pready), 128'(x_rdy));
                        chk("s_prdata", 128'(s_prdata), 128'(x_rd));
                        chk("s_pslverr", 128'(s_pslverr), 128'(x_err));
                        chk("timeout_evt", 128'(timeout_evt), 128'(e.to));
                        chk("m_cmd", {63'd0, m_pwrite, m_paddr, m_pwdata}, {63'd0, e.wr, e.addr, e.wdata});
                    end
                end else if (timeout_evt) begin
                    checks++; failures++;
                    $display("FAIL stray_timeout: timeout_evt 1 with no response expected");
                end
            end
        end
    end

    task automatic add_txn(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wr = w; t.wdata = d;
        mq[i].push_back(t);
        pend_q[i].push_back(t);
    endtask

    // Reference model: serve pending initiators in round-robin order starting at mptr.
    task automatic plan();
        int   g, x;
        txn_t t;
        rsp_t r;
        exp_t e;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mq[(mptr + k) % N].size() > 0) g = (mptr + k) % N;
            end
            if (g < 0) break;
            t = mq[g].pop_front();
            if (forced_dly.size() > 0) begin
                r.dly = forced_dly.pop_front();
            end else begin
                x = $urandom_range(0, 9);
                r.dly = (x < 7) ? $urandom_range(1, 5) : (x == 7) ? TO : $urandom_range(TO + 1, TO + 4);
            end
            if (forced_data.size() > 0) begin
                r.rdata = forced_data.pop_front();
                r.err   = 1'b0;
            end else begin
                r.rdata = $urandom;
                r.err   = ($urandom_range(0, 3) == 0);
            end
            rsp_q.push_back(r);
            e.idx = g; e.addr = t.addr; e.wr = t.wr; e.wdata = t.wdata;
            e.to    = (r.dly > TO);
            e.rdata = e.to ? 32'd0 : r.rdata;
            e.err   = e.to ? 1'b1 : r.err;
            exp_q.push_back(e);
            mptr = (g + 1) % N;
        end
    endtask

    task automatic wait_idle();
        int busy;
        for (int c = 0; c < 3000; c++) begin
            @(negedge apb_clk);
            busy = exp_q.size() + rsp_q.size();
            for (int i = 0; i < N; i++) busy += pend_q[i].size();
            if (busy == 0 && !m_psel) return;
        end
        checks++; failures++;
        $display("FAIL idle_wait: outstanding %0d responses after cycle budget", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stalled");
    endtask

    initial begin : stim
        mptr = 0;
        apb_reset = 1'b1;
        #23;
        chk("rst_m_ctrl", {m_psel, m_penable, m_pwrite}, 3'b000);
        chk("rst_m_data", {m_paddr, m_pwdata}, 64'd0);
        chk("rst_s_resp", {s_pready, s_pslverr, s_prdata, timeout_evt}, '0);
        @(negedge apb_clk);
        apb_reset = 1'b0;
        @(negedge apb_clk);

        // Contention: both present in the same cycle, 0 served first.
        add_txn(0, 32'h10, 1'b1, $urandom);
        add_txn(1, 32'h20, 1'b1, $urandom);
        plan();
        wait_idle();

        // Single read with phase latency checks.
        add_txn(0, 32'h1000, 1'b0, 32'd0);
        forced_dly.push_back(3);
        forced_data.push_back(32'hDEADBEEF);
        plan();
        @(posedge apb_clk);
        @(posedge apb_clk); #1;
        chk("setup_phase", {m_psel, m_penable}, 2'b10);
        @(posedge apb_clk); #1;
        chk("access_phase", {m_psel, m_penable}, 2'b11);
        wait_idle();

        // Timeout on the first, second initiator waits out the drain.
        add_txn(2, 32'h2222_0000, 1'b0, 32'd0);
        add_txn(0, 32'h0000_0300, 1'b1, 32'hA5A5_5A5A);
        forced_dly.push_back(TO + 4);
        forced_dly.push_back(2);
        plan();
        wait_idle();

        // Ready on exactly the watchdog cycle.
        add_txn(1, 32'h0000_0444, 1'b0, 32'd0);
        forced_dly.push_back(TO);
        plan();
        wait_idle();

        // Reset mid-access: abort with no response, pointer back to 0.
        add_txn(1, 32'h0000_0555, 1'b1, 32'h1234_5678);
        forced_dly.push_back(10);
        plan();
        for (int c = 0; c < 20 && !m_penable; c++) @(negedge apb_clk);
        chk("pre_reset_access", 128'(m_penable), 128'(1));
        apb_reset = 1'b1;
        #1;
        chk("reset_abort", {m_psel, m_penable, s_pready}, '0);
        exp_q.delete();
        rsp_q.delete();
        for (int i = 0; i < N; i++) begin
            pend_q[i].delete();
            mq[i].delete();
        end
        mptr = 0;
        repeat (2) @(negedge apb_clk);
        apb_reset = 1'b0;
        @(negedge apb_clk);
        add_txn(2, 32'h0000_0662, 1'b0, 32'd0);
        add_txn(1, 32'h0000_0661, 1'b0, 32'd0);
        plan();
        wait_idle();

        // Fairness: everyone requesting continuously.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++)
                add_txn(i, 32'h7000 + 32'(16 * r + i), 1'($urandom_range(0, 1)), $urandom);
        plan();
        wait_idle();

        for (int round = 0; round < 10; round++) begin
            for (int i = 0; i < N; i++)
                for (int n = $urandom_range(0, 3); n > 0; n--)
                    add_txn(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
            plan();
            wait_idle();
        end

        repeat (3) @(negedge apb_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
